// File: rtl/branch_predictor_if.sv
// Fetch/execute side bundle for the bimodal branch predictor: lookup request,
// registered prediction, resolved-branch update and statistics outputs.
interface branch_predictor_if;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [2:0]  upd_funct3;
  logic        upd_taken;
  logic        upd_pred;
  logic        mispredict;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  modport master (
    output lookup_valid, lookup_pc, upd_valid, upd_pc, upd_funct3, upd_taken, upd_pred,
    input  pred_valid, pred_taken, mispredict, branch_count, mispredict_count
  );

  modport slave (
    input  lookup_valid, lookup_pc, upd_valid, upd_pc, upd_funct3, upd_taken, upd_pred,
    output pred_valid, pred_taken, mispredict, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal predictor: 2^IDX_BITS two-bit saturating counters indexed by PC[IDX_BITS+1:2],
// registered predictions, mispredict flag and saturating branch/mispredict statistics.
module branch_predictor #(
  parameter int IDX_BITS = 6
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);
  localparam int DEPTH = 1 << IDX_BITS;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_funct3_t;

  function automatic logic [1:0] ctr_train(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (ctr == 2'b11) ? ctr : ctr + 2'b01;
    end else begin
      nxt = (ctr == 2'b00) ? ctr : ctr - 2'b01;
    end
    return nxt;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

  logic [DEPTH-1:0][1:0] ctr_q, ctr_d;
  logic                  pred_valid_q, pred_valid_d;
  logic                  pred_taken_q, pred_taken_d;
  logic                  mispredict_q, mispredict_d;
  logic [31:0]           branch_count_q, branch_count_d;
  logic [31:0]           mispredict_count_q, mispredict_count_d;

  logic [IDX_BITS-1:0]   lk_idx_s;
  logic [IDX_BITS-1:0]   upd_idx_s;
  logic                  funct3_ok_s;
  logic                  upd_ok_s;
  logic                  unused_pc_bits_s;

  assign lk_idx_s  = bp.lookup_pc[IDX_BITS+1:2];
  assign upd_idx_s = bp.upd_pc[IDX_BITS+1:2];
  assign unused_pc_bits_s = ^{bp.lookup_pc[31:IDX_BITS+2], bp.lookup_pc[1:0],
                              bp.upd_pc[31:IDX_BITS+2], bp.upd_pc[1:0]};

  // Only real conditional-branch encodings train the table; 010/011 are not branches.
  always_comb begin
    funct3_ok_s = 1'b0;
    case (branch_funct3_t'(bp.upd_funct3))
      F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: funct3_ok_s = 1'b1;
      default:                                          funct3_ok_s = 1'b0;
    endcase
  end

  assign upd_ok_s = bp.upd_valid & funct3_ok_s;

  // Next-state: the lookup reads ctr_q, so a same-index update this edge is read-old.
  always_comb begin
    ctr_d              = ctr_q;
    pred_valid_d       = 1'b0;
    pred_taken_d       = pred_taken_q;
    mispredict_d       = 1'b0;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;

    if (bp.lookup_valid) begin
      pred_valid_d = 1'b1;
      pred_taken_d = ctr_q[lk_idx_s][1];
    end else begin
      pred_valid_d = 1'b0;
      pred_taken_d = pred_taken_q;
    end

    if (upd_ok_s) begin
      ctr_d[upd_idx_s] = ctr_train(ctr_q[upd_idx_s], bp.upd_taken);
      branch_count_d   = sat_inc(branch_count_q);
      if (bp.upd_taken != bp.upd_pred) begin
        mispredict_d       = 1'b1;
        mispredict_count_d = sat_inc(mispredict_count_q);
      end else begin
        mispredict_d       = 1'b0;
        mispredict_count_d = mispredict_count_q;
      end
    end else begin
      ctr_d          = ctr_q;
      branch_count_d = branch_count_q;
    end
  end

  // State registers; reset puts every counter at weak-not-taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_q              <= {DEPTH{2'b01}};
      pred_valid_q       <= 1'b0;
      pred_taken_q       <= 1'b0;
      mispredict_q       <= 1'b0;
      branch_count_q     <= 32'd0;
      mispredict_count_q <= 32'd0;
    end else begin
      ctr_q              <= ctr_d;
      pred_valid_q       <= pred_valid_d;
      pred_taken_q       <= pred_taken_d;
      mispredict_q       <= mispredict_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign bp.pred_valid       = pred_valid_q;
  assign bp.pred_taken       = pred_taken_q;
  assign bp.mispredict       = mispredict_q;
  assign bp.branch_count     = branch_count_q;
  assign bp.mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed lookups/updates push expected
// responses; a negedge monitor pops and compares whenever a response is due.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  typedef struct packed {
    logic        mis;
    logic [31:0] bc;
    logic [31:0] mc;
  } upd_exp_t;

  logic     exp_pred[$];
  upd_exp_t exp_upd[$];

  branch_predictor_if bus();

  branch_predictor #(.IDX_BITS(6)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: note what was presented on each edge, then compare on the following negedge.
  logic lk_seen  = 1'b0;
  logic up_seen  = 1'b0;
  logic rst_seen = 1'b0;
  logic last_pred = 1'b0;

  always @(posedge clk) begin
    lk_seen  <= bus.lookup_valid && !rst;
    up_seen  <= bus.upd_valid && !rst;
    rst_seen <= rst;
  end

  always @(negedge clk) begin
    upd_exp_t e;
    logic     p;
    if (rst_seen) last_pred = 1'b0;
    if (lk_seen) begin
      check("pred_valid", {31'd0, bus.pred_valid}, 32'd1);
      if (exp_pred.size() == 0) begin
        check("pred_unexpected", 32'd1, 32'd0);
      end else begin
        p = exp_pred.pop_front();
        check("pred_taken", {31'd0, bus.pred_taken}, {31'd0, p});
        last_pred = p;
      end
    end else begin
      check("pred_valid_idle", {31'd0, bus.pred_valid}, 32'd0);
      check("pred_taken_hold", {31'd0, bus.pred_taken}, {31'd0, last_pred});
    end
    if (up_seen) begin
      if (exp_upd.size() == 0) begin
        check("upd_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_upd.pop_front();
        check("mispredict", {31'd0, bus.mispredict}, {31'd0, e.mis});
        check("branch_count", bus.branch_count, e.bc);
        check("mispredict_count", bus.mispredict_count, e.mc);
      end
    end else begin
      check("mispredict_idle", {31'd0, bus.mispredict}, 32'd0);
    end
  end

  task automatic apply(input logic lv, input logic [31:0] lpc, input logic uv,
                       input logic [31:0] upc, input logic [2:0] f3,
                       input logic ut, input logic up);
    bus.lookup_valid = lv;
    bus.lookup_pc    = lpc;
    bus.upd_valid    = uv;
    bus.upd_pc       = upc;
    bus.upd_funct3   = f3;
    bus.upd_taken    = ut;
    bus.upd_pred     = up;
  endtask

  task automatic idle();
    @(negedge clk);
    apply(1'b0, 32'd0, 1'b0, 32'd0, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic lookup(input logic [31:0] pc, input logic ep);
    @(negedge clk);
    apply(1'b1, pc, 1'b0, 32'd0, 3'b000, 1'b0, 1'b0);
    exp_pred.push_back(ep);
  endtask

  task automatic update(input logic [31:0] pc, input logic [2:0] f3, input logic t,
                        input logic p, input logic em, input logic [31:0] ebc,
                        input logic [31:0] emc);
    @(negedge clk);
    apply(1'b0, 32'd0, 1'b1, pc, f3, t, p);
    exp_upd.push_back('{mis: em, bc: ebc, mc: emc});
  endtask

  task automatic both(input logic [31:0] lpc, input logic ep, input logic [31:0] upc,
                      input logic [2:0] f3, input logic t, input logic p,
                      input logic em, input logic [31:0] ebc, input logic [31:0] emc);
    @(negedge clk);
    apply(1'b1, lpc, 1'b1, upc, f3, t, p);
    exp_pred.push_back(ep);
    exp_upd.push_back('{mis: em, bc: ebc, mc: emc});
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pred_valid"}, {31'd0, bus.pred_valid}, 32'd0);
    check({tag, "_pred_taken"}, {31'd0, bus.pred_taken}, 32'd0);
    check({tag, "_mispredict"}, {31'd0, bus.mispredict}, 32'd0);
    check({tag, "_branch_count"}, bus.branch_count, 32'd0);
    check({tag, "_mispredict_count"}, bus.mispredict_count, 32'd0);
  endtask

  initial begin
    apply(1'b0, 32'd0, 1'b0, 32'd0, 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Weak-NT after reset, then train to strong-T with saturation.
    lookup(32'h0000_0040, 1'b0);
    update(32'h0000_0040, 3'b000, 1'b1, 1'b0, 1'b1, 32'd1, 32'd1);
    update(32'h0000_0040, 3'b000, 1'b1, 1'b0, 1'b1, 32'd2, 32'd2);
    update(32'h0000_0040, 3'b000, 1'b1, 1'b0, 1'b1, 32'd3, 32'd3);
    lookup(32'h0000_0040, 1'b1);
    update(32'h0000_0040, 3'b000, 1'b0, 1'b1, 1'b1, 32'd4, 32'd4);
    lookup(32'h0000_0040, 1'b1);
    update(32'h0000_0040, 3'b001, 1'b0, 1'b0, 1'b0, 32'd5, 32'd4);
    lookup(32'h0000_0040, 1'b0);

    // Same-cycle lookup/update: read-old, new value visible next edge.
    both(32'h0000_0080, 1'b0, 32'h0000_0080, 3'b100, 1'b1, 1'b0, 1'b1, 32'd6, 32'd5);
    lookup(32'h0000_0080, 1'b1);

    // Back-to-back updates to one index: 01 -> 00 -> 00 -> 01.
    update(32'h0000_00C0, 3'b101, 1'b0, 1'b0, 1'b0, 32'd7, 32'd5);
    update(32'h0000_00C0, 3'b101, 1'b0, 1'b0, 1'b0, 32'd8, 32'd5);
    update(32'h0000_00C0, 3'b110, 1'b1, 1'b0, 1'b1, 32'd9, 32'd6);
    lookup(32'h0000_00C0, 1'b0);

    // Aliasing on index 1, neighbour index 2 untouched, pc[1:0] ignored.
    update(32'h0000_0004, 3'b111, 1'b1, 1'b1, 1'b0, 32'd10, 32'd6);
    lookup(32'h0000_0104, 1'b1);
    lookup(32'h0000_0008, 1'b0);
    lookup(32'h0000_0107, 1'b1);

    // Non-branch funct3 encodings are ignored.
    update(32'h0000_0008, 3'b010, 1'b1, 1'b0, 1'b0, 32'd10, 32'd6);
    update(32'h0000_0008, 3'b011, 1'b1, 1'b0, 1'b0, 32'd10, 32'd6);
    lookup(32'h0000_0008, 1'b0);

    // Mispredict counter saturation.
    idle();
    force dut.mispredict_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.mispredict_count_q;
    update(32'h0000_0008, 3'b000, 1'b1, 1'b0, 1'b1, 32'd11, 32'hFFFF_FFFF);
    update(32'h0000_0008, 3'b000, 1'b1, 1'b0, 1'b1, 32'd12, 32'hFFFF_FFFF);
    update(32'h0000_0008, 3'b000, 1'b1, 1'b0, 1'b1, 32'd13, 32'hFFFF_FFFF);

    // Mid-stream reset overrides a concurrent lookup and update.
    @(negedge clk);
    apply(1'b1, 32'h0000_0008, 1'b1, 32'h0000_0008, 3'b000, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midreset");
    rst = 1'b0;
    apply(1'b0, 32'd0, 1'b0, 32'd0, 3'b000, 1'b0, 1'b0);

    lookup(32'h0000_0008, 1'b0);
    lookup(32'h0000_0040, 1'b0);
    lookup(32'h0000_0080, 1'b0);
    update(32'h0000_0080, 3'b000, 1'b1, 1'b1, 1'b0, 32'd1, 32'd0);
    repeat (3) idle();

    check("queue_drain", exp_pred.size() + exp_upd.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Bimodal branch predictor paired with the branch comparator in the RV32I datapath. Fetch issues a PC lookup and receives a registered taken/not-taken prediction one cycle later. When the comparator resolves a branch, execute returns the actual outcome, and the predictor trains a table of 2-bit saturating counters. The block also flags the mispredict and keeps branch and mispredict statistics for the control path and the bench.

## Interface
Parameters:
- IDX_BITS, 6, log2 of the table depth; the table has 2^IDX_BITS entries, 64 by default.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- lookup_valid  in  1  fetch requests a prediction this cycle.
- lookup_pc  in  32  PC of the fetched instruction.
- pred_valid  out  1  registered; high exactly one cycle after an accepted lookup.
- pred_taken  out  1  registered prediction; 1 = taken.
- upd_valid  in  1  a resolved branch is presented this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_funct3  in  3  branch_funct3_t of the resolved branch.
- upd_taken  in  1  actual outcome, taken directly from the comparator result.
- upd_pred  in  1  prediction that fetch used for this branch.
- mispredict  out  1  registered one-cycle pulse when upd_taken != upd_pred.
- branch_count  out  32  number of accepted updates, saturating.
- mispredict_count  out  32  number of accepted mispredicts, saturating.

## Operation
- Table: 2^IDX_BITS two-bit counters encoded 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. The prediction is counter[1].
- Index: lookup uses pc[IDX_BITS+1:2] and update uses upd_pc[IDX_BITS+1:2]. pc[1:0] is ignored.
- Reset:
  - all counters go to 01.
  - pred_valid, pred_taken and mispredict go to 0.
  - both statistics counters go to 0.
  - reset completes in one cycle and overrides any lookup or update in the same cycle.
- Lookup: on an edge with lookup_valid=1:
  - pred_taken <= counter[idx][1] and pred_valid <= 1.
  - without a lookup, pred_valid <= 0 and pred_taken holds its value.
- Update acceptance: an update is accepted when upd_valid=1 and upd_funct3 is one of beq, bne, blt, bge, bltu or bgeu. The encodings 3'b010 and 3'b011 are rejected: no table write, no statistics change, mispredict <= 0.
- Training on an accepted update:
  - if upd_taken=1 the counter increments, saturating at 11.
  - if upd_taken=0 the counter decrements, saturating at 00.
- Statistics on an accepted update:
  - branch_count increments.
  - if upd_taken != upd_pred, mispredict_count increments and mispredict <= 1; otherwise mispredict <= 0.
  - both statistics counters saturate at 32'hFFFF_FFFF and never wrap.
- Simultaneous lookup and update:
  - both are processed on the same edge.
  - if they hit the same index, the lookup returns the pre-update counter (read-old). The written value is visible to lookups on the next edge.
  - lookups and updates to different indices are independent.
- Back-to-back updates to the same index in consecutive cycles each see the previous cycle's write, so there is no lost update.

## Timing
- Lookup latency is 1 cycle: request at edge N, then pred_valid and pred_taken are valid after edge N and hold during cycle N+1.
- Lookup throughput is one per cycle.
- Update-to-mispredict latency is 1 cycle. The mispredict pulse lasts exactly one cycle unless the next cycle also carries an accepted mispredicting update.
- Statistics outputs are registered and reflect an update one cycle after it is presented.
- There is no backpressure. Lookups and updates are always accepted.
- If rst is asserted mid-stream, every output is at its reset value after that edge. In-flight predictions are discarded and pred_valid=0.

## Test plan
- Reset, then lookup of PC 0x0000_0040: next cycle pred_valid=1, pred_taken=0 (weak-NT), both counts 0.
- Three updates at PC 0x40 with taken=1 and pred=0, then a lookup: counter goes 01 to 10 to 11 and saturates at 11. pred_taken=1, mispredict pulses each update cycle, mispredict_count=3, branch_count=3.
- Same-cycle lookup and update at PC 0x80 (counter 01, upd_taken=1): returned pred_taken=0 (read-old). A lookup one cycle later returns 1.
- Aliasing: update PC 0x0000_0004 taken with IDX_BITS=6, then look up PC 0x0000_0104. The lookup reads the same entry and returns the trained value. PC 0x0000_0008 is unaffected.
- Update with upd_funct3=3'b010 and upd_valid=1: no counter change, counts unchanged, mispredict=0.
- Force mispredict_count to 32'hFFFF_FFFE, then apply 3 mispredicting updates: the count stops at 32'hFFFF_FFFF. Assert rst mid-sequence: all outputs 0 on the next cycle and table entries back to 01.
